// File: rtl/demux_1to2.sv
// Registered 1-to-2 valid/ready stream demultiplexer.
// Each output owns a 2-entry FIFO and a wrapping transfer counter.

module demux_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_full,
   output logic [15:0]      o_cnt
);

   logic [1:0]       r_count;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [15:0]      r_cnt;

   // Head register is the output, kept at zero whenever the FIFO is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
         r_cnt   <= 16'd0;
      end else begin
         if (i_pop) begin
            r_cnt <= r_cnt + 16'd1;
         end
         case (r_count)
            2'd0: begin
               if (i_push) begin
                  r_head  <= i_data;
                  r_count <= 2'd1;
               end
            end
            2'd1: begin
               if (i_push && i_pop) begin
                  r_head <= i_data;
               end else if (i_push) begin
                  r_tail  <= i_data;
                  r_count <= 2'd2;
               end else if (i_pop) begin
                  r_head  <= '0;
                  r_count <= 2'd0;
               end
            end
            default: begin
               if (i_pop) begin
                  r_head  <= r_tail;
                  r_tail  <= '0;
                  r_count <= 2'd1;
               end
            end
         endcase
      end
   end

   assign o_data  = r_head;
   assign o_valid = (r_count != 2'd0);
   assign o_full  = (r_count == 2'd2);
   assign o_cnt   = r_cnt;

endmodule

module demux_1to2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y0_data,
   output logic             y0_valid,
   input  logic             y0_ready,
   output logic [WIDTH-1:0] y1_data,
   output logic             y1_valid,
   input  logic             y1_ready,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1
);

   logic w_full0;
   logic w_full1;
   logic w_acc;
   logic w_push0;
   logic w_push1;
   logic w_pop0;
   logic w_pop1;

   // Full-and-pop does not admit a push that cycle, so ready ignores y*_ready.
   assign in_ready = rst_n && !(in_sel ? w_full1 : w_full0);
   assign w_acc    = in_valid && in_ready;
   assign w_push0  = w_acc && !in_sel;
   assign w_push1  = w_acc && in_sel;
   assign w_pop0   = y0_valid && y0_ready;
   assign w_pop1   = y1_valid && y1_ready;

   demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push0),
      .i_data  (in_data),
      .i_pop   (w_pop0),
      .o_data  (y0_data),
      .o_valid (y0_valid),
      .o_full  (w_full0),
      .o_cnt   (cnt0)
   );

   demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push1),
      .i_data  (in_data),
      .i_pop   (w_pop1),
      .o_data  (y1_data),
      .o_valid (y1_valid),
      .o_full  (w_full1),
      .o_cnt   (cnt1)
   );

endmodule

// File: tb/tb_demux_1to2.sv
// Scoreboard bench for demux_1to2: directed words queued per output,
// a negedge monitor pops and compares on every output handshake.

module tb_demux_1to2;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  y0_data;
   logic        y0_valid;
   logic        y0_ready;
   logic [7:0]  y1_data;
   logic        y1_valid;
   logic        y1_ready;
   logic [15:0] cnt0;
   logic [15:0] cnt1;

   int errors = 0;
   int checks = 0;
   int stalls = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   demux_1to2 #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y0_data  (y0_data),
      .y0_valid (y0_valid),
      .y0_ready (y0_ready),
      .y1_data  (y1_data),
      .y1_valid (y1_valid),
      .y1_ready (y1_ready),
      .cnt0     (cnt0),
      .cnt1     (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a handshake seen at negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (y0_valid && y0_ready) begin
            if (q0.size() == 0) chk("y0 unexpected word", {24'd0, y0_data}, 32'hXX);
            else chk("y0 data", {24'd0, y0_data}, {24'd0, q0.pop_front()});
         end
         if (y1_valid && y1_ready) begin
            if (q1.size() == 0) chk("y1 unexpected word", {24'd0, y1_data}, 32'hXX);
            else chk("y1 data", {24'd0, y1_data}, {24'd0, q1.pop_front()});
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic s);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      in_data  = d;
      in_sel   = s;
      in_valid = 1'b1;
      while (n < 20) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         n++;
         stalls++;
      end
      if (ok) begin
         if (s) q1.push_back(d);
         else q0.push_back(d);
      end else begin
         chk("send timeout", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (n < 40 && (q0.size() != 0 || q1.size() != 0 || y0_valid || y1_valid)) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 40) chk("drain timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      y0_ready = 1'b1;
      y1_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      q0.delete();
      q1.delete();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b0;
      in_data  = 8'h5A;
      in_sel   = 1'b0;
      in_valid = 1'b1;
      y0_ready = 1'b1;
      y1_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst y0_valid", {31'd0, y0_valid}, 32'd0);
      chk("rst y1_valid", {31'd0, y1_valid}, 32'd0);
      chk("rst y0_data", {24'd0, y0_data}, 32'd0);
      chk("rst y1_data", {24'd0, y1_data}, 32'd0);
      chk("rst cnt0", {16'd0, cnt0}, 32'd0);
      chk("rst cnt1", {16'd0, cnt1}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("post-rst in_ready sel0", {31'd0, in_ready}, 32'd1);
      in_sel = 1'b1;
      #1;
      chk("post-rst in_ready sel1", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Alternating route
      stalls = 0;
      send(8'hA0, 1'b0);
      chk("latency y0_valid", {31'd0, y0_valid}, 32'd1);
      chk("latency y0_data", {24'd0, y0_data}, 32'hA0);
      send(8'hB1, 1'b1);
      send(8'hA2, 1'b0);
      drain();
      chk("alt stalls", stalls, 32'd0);
      chk("alt cnt0", {16'd0, cnt0}, 32'd2);
      chk("alt cnt1", {16'd0, cnt1}, 32'd1);

      // Backpressure and order
      do_reset();
      y0_ready = 1'b0;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      in_data = 8'h33;
      in_sel = 1'b0;
      in_valid = 1'b1;
      #1;
      chk("bp in_ready full", {31'd0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("bp in_ready held", {31'd0, in_ready}, 32'd0);
      chk("bp y0_data head", {24'd0, y0_data}, 32'h11);
      y0_ready = 1'b1;
      send(8'h33, 1'b0);
      drain();
      chk("bp cnt0", {16'd0, cnt0}, 32'd3);

      // Full plus simultaneous pop
      do_reset();
      y0_ready = 1'b0;
      send(8'h44, 1'b0);
      send(8'h55, 1'b0);
      y0_ready = 1'b1;
      in_data = 8'h66;
      in_sel = 1'b0;
      in_valid = 1'b1;
      #1;
      chk("fullpop in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("fullpop next in_ready", {31'd0, in_ready}, 32'd1);
      chk("fullpop head", {24'd0, y0_data}, 32'h55);
      send(8'h66, 1'b0);
      drain();
      chk("fullpop cnt0", {16'd0, cnt0}, 32'd3);

      // Independence
      do_reset();
      y0_ready = 1'b0;
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      stalls = 0;
      send(8'h77, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("indep stalls", stalls, 32'd0);
      chk("indep cnt1", {16'd0, cnt1}, 32'd1);
      chk("indep y1_valid", {31'd0, y1_valid}, 32'd0);
      chk("indep cnt0", {16'd0, cnt0}, 32'd0);
      chk("indep y0 head", {24'd0, y0_data}, 32'h12);
      y0_ready = 1'b1;
      drain();
      chk("indep final cnt0", {16'd0, cnt0}, 32'd2);

      // Counter wrap
      do_reset();
      for (int i = 0; i < 65536; i++) begin
         send(i[7:0], 1'b1);
      end
      drain();
      chk("wrap cnt1", {16'd0, cnt1}, 32'd0);
      chk("wrap cnt0", {16'd0, cnt0}, 32'd0);

      // Async reset mid-stream
      y0_ready = 1'b0;
      send(8'hC3, 1'b0);
      send(8'h3C, 1'b0);
      chk("ares y0_valid before", {31'd0, y0_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ares y0_valid", {31'd0, y0_valid}, 32'd0);
      chk("ares y0_data", {24'd0, y0_data}, 32'd0);
      chk("ares cnt1", {16'd0, cnt1}, 32'd0);
      chk("ares in_ready", {31'd0, in_ready}, 32'd0);
      q0.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      y0_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("ares words lost", {31'd0, y0_valid}, 32'd0);
      chk("ares cnt0", {16'd0, cnt0}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
